// File: rtl/decode_stage.sv
// Decode stage: splits RV64 instruction words into EX-stage fields behind a registered output slot.
// Optional DECODE_SKID_EN adds a one-entry skid buffer so if_ready is driven from a register.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [63:0] if_pc,
  output logic        if_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [63:0] ex_pc,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic [11:0] ex_immed,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_we,
  output logic        ex_illegal
);

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] immed;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } bundle_t;

  function automatic bundle_t decode(input logic [31:0] inst, input logic [63:0] pc);
    bundle_t    b;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       rtype;
    logic       itype;
    op    = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    legal = 1'b0;
    rtype = 1'b0;
    itype = 1'b0;
    case (op)
      7'b0110011: begin
        rtype = 1'b1;
        legal = (f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
                (f7 == 7'h00 && (f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd4));
      end
      7'b0111011: begin
        rtype = 1'b1;
        legal = (f3 == 3'd0) && (f7 == 7'h00 || f7 == 7'h20);
      end
      7'b0010011: begin
        itype = 1'b1;
        legal = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      7'b0011011: begin
        itype = 1'b1;
        legal = (f3 == 3'd0);
      end
      default: ;
    endcase
    b.pc      = pc;
    b.opcode  = op;
    b.funct3  = f3;
    b.funct7  = f7;
    b.immed   = (itype && legal) ? inst[31:20] : '0;
    b.rs1     = inst[19:15];
    b.rs2     = rtype ? inst[24:20] : '0;
    b.rd      = inst[11:7];
    b.rd_we   = legal && (inst[11:7] != 5'd0);
    b.illegal = !legal;
    return b;
  endfunction

  bundle_t slot_q;
  logic    slot_v;
  bundle_t dec_in;
  logic    slot_free;
  logic    accept;

  assign dec_in    = decode(if_inst, if_pc);
  assign slot_free = !slot_v || ex_ready;
  assign accept    = if_valid && if_ready;

`ifdef DECODE_SKID_EN
  logic [31:0] skid_inst;
  logic [63:0] skid_pc;
  logic        skid_v;
  bundle_t     dec_skid;

  assign dec_skid = decode(skid_inst, skid_pc);
  assign if_ready = !skid_v && !reset && !flush;

  // Skid entry always refills the slot first; if_ready is low while it is occupied.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot_v    <= 1'b0;
      slot_q    <= '0;
      skid_v    <= 1'b0;
      skid_inst <= '0;
      skid_pc   <= '0;
    end else if (skid_v) begin
      if (slot_free) begin
        slot_q <= dec_skid;
        slot_v <= 1'b1;
        skid_v <= 1'b0;
      end
    end else if (accept) begin
      if (slot_free) begin
        slot_q <= dec_in;
        slot_v <= 1'b1;
      end else begin
        skid_inst <= if_inst;
        skid_pc   <= if_pc;
        skid_v    <= 1'b1;
      end
    end else if (slot_v && ex_ready) begin
      slot_v <= 1'b0;
    end
  end
`else
  assign if_ready = slot_free && !reset && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      slot_v <= 1'b0;
      slot_q <= '0;
    end else if (accept) begin
      slot_q <= dec_in;
      slot_v <= 1'b1;
    end else if (slot_v && ex_ready) begin
      slot_v <= 1'b0;
    end
  end
`endif

  assign ex_valid   = slot_v;
  assign ex_pc      = slot_q.pc;
  assign ex_opcode  = slot_q.opcode;
  assign ex_funct3  = slot_q.funct3;
  assign ex_funct7  = slot_q.funct7;
  assign ex_immed   = slot_q.immed;
  assign ex_rs1     = slot_q.rs1;
  assign ex_rs2     = slot_q.rs2;
  assign ex_rd      = slot_q.rd;
  assign ex_rd_we   = slot_q.rd_we;
  assign ex_illegal = slot_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: queue-based reference model plus directed literal checks.
// Honours DECODE_SKID_EN to select the expected capacity (2 with skid, 1 without).
module tb_decode_stage;

`ifdef DECODE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, if_valid, if_ready, ex_valid, ex_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc, ex_pc;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic [11:0] ex_immed;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rd_we, ex_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_immed(ex_immed), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] inst;
    bit [63:0] pc;
  } entry_t;

  entry_t q[$];
  int errors = 0;
  int checks = 0;
  int dut_accepts = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Supported encodings expressed as a lookup over (opcode, funct3, funct7).
  function automatic bit legal_m(input bit [31:0] i);
    bit [6:0] op = i[6:0];
    bit [2:0] f3 = i[14:12];
    bit [6:0] f7 = i[31:25];
    bit [16:0] key = {op, f3, f7};
    bit [16:0] rkeys[7] = '{{7'h33, 3'd0, 7'h00}, {7'h33, 3'd0, 7'h20}, {7'h33, 3'd7, 7'h00},
                            {7'h33, 3'd6, 7'h00}, {7'h33, 3'd4, 7'h00},
                            {7'h3B, 3'd0, 7'h00}, {7'h3B, 3'd0, 7'h20}};
    foreach (rkeys[k]) if (key == rkeys[k]) return 1;
    if (op == 7'h13 && (f3 == 0 || f3 == 4 || f3 == 6 || f3 == 7)) return 1;
    if (op == 7'h1B && f3 == 0) return 1;
    return 0;
  endfunction

  task automatic check_head(input entry_t e);
    bit [31:0] i = e.inst;
    bit lg = legal_m(i);
    bit is_r = (i[6:0] == 7'h33) || (i[6:0] == 7'h3B);
    bit is_i = (i[6:0] == 7'h13) || (i[6:0] == 7'h1B);
    chk("pc", ex_pc, e.pc);
    chk("opcode", 64'(ex_opcode), 64'(i[6:0]));
    chk("funct3", 64'(ex_funct3), 64'(i[14:12]));
    chk("funct7", 64'(ex_funct7), 64'(i[31:25]));
    chk("immed", 64'(ex_immed), (lg && is_i) ? 64'(i[31:20]) : 64'd0);
    chk("rs1", 64'(ex_rs1), 64'(i[19:15]));
    chk("rs2", 64'(ex_rs2), is_r ? 64'(i[24:20]) : 64'd0);
    chk("rd", 64'(ex_rd), 64'(i[11:7]));
    chk("rd_we", 64'(ex_rd_we), 64'(lg && i[11:7] != 0));
    chk("illegal", 64'(ex_illegal), 64'(!lg));
  endtask

  task automatic step(input bit v, input bit [31:0] inst, input bit [63:0] pc,
                      input bit rdy, input bit fl, input bit rst);
    bit exp_rdy;
    entry_t e;
    if_valid = v; if_inst = inst; if_pc = pc; ex_ready = rdy; flush = fl; reset = rst;
    @(negedge clk);
    if (rst || fl) exp_rdy = 0;
    else if (CAP == 2) exp_rdy = (q.size() < 2);
    else exp_rdy = (q.size() == 0) || rdy;
    chk("if_ready", 64'(if_ready), 64'(exp_rdy));
    chk("ex_valid", 64'(ex_valid), 64'(q.size() != 0));
    if (q.size() != 0) check_head(q[0]);
    if (if_valid && if_ready) dut_accepts++;
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (v && exp_rdy) begin
        e.inst = inst; e.pc = pc;
        q.push_back(e);
      end
    end
    #1;
  endtask

  function automatic bit [31:0] rand_inst();
    bit [6:0] ops[5] = '{7'h33, 7'h13, 7'h1B, 7'h3B, 7'h00};
    bit [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    bit [31:0] r = $urandom;
    bit [6:0] op = ops[$urandom_range(0, 4)];
    if (op == 7'h00) return r;
    return {f7s[$urandom_range(0, 3)], r[24:15], r[14:12], r[11:7], op};
  endfunction

  task automatic expect_zero_outputs();
    chk("zero_valid", 64'(ex_valid), 64'd0);
    chk("zero_pc", ex_pc, 64'd0);
    chk("zero_fields", 64'({ex_opcode, ex_funct3, ex_funct7, ex_immed, ex_rs1, ex_rs2, ex_rd}), 64'd0);
    chk("zero_flags", 64'({ex_rd_we, ex_illegal}), 64'd0);
  endtask

  initial begin
    bit [31:0] bp_inst[4] = '{32'h00A00093, 32'h40208133, 32'h0020C1B3, 32'h0FF1F213};
    int j;
    int acc0;
    bit [63:0] pc_y;

    if_valid = 0; if_inst = '0; if_pc = '0; ex_ready = 0; flush = 0; reset = 1;
    #1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    expect_zero_outputs();
    reset = 0;
    #1;
    chk("ready_after_reset", 64'(if_ready), 64'd1);

    // ADDI x5,x1,-1
    step(1, 32'hFFF08293, 64'h1000, 1, 0, 0);
    chk("addi_opcode", 64'(ex_opcode), 64'h13);
    chk("addi_funct3", 64'(ex_funct3), 64'd0);
    chk("addi_immed", 64'(ex_immed), 64'hFFF);
    chk("addi_rs1", 64'(ex_rs1), 64'd1);
    chk("addi_rd", 64'(ex_rd), 64'd5);
    chk("addi_flags", 64'({ex_valid, ex_rd_we, ex_illegal}), 64'b110);
    // SUBW x3,x4,x5
    step(1, 32'h405201BB, 64'h1004, 1, 0, 0);
    chk("subw_opcode", 64'(ex_opcode), 64'h3B);
    chk("subw_funct7", 64'(ex_funct7), 64'h20);
    chk("subw_rs2", 64'(ex_rs2), 64'd5);
    chk("subw_immed", 64'(ex_immed), 64'd0);
    chk("subw_rd_we", 64'(ex_rd_we), 64'd1);
    // MUL is outside the supported set
    step(1, 32'h02208033, 64'h1008, 1, 0, 0);
    chk("mul_illegal", 64'({ex_illegal, ex_rd_we}), 64'b10);
    // ADD x0,x1,x2
    step(1, 32'h00208033, 64'h100C, 1, 0, 0);
    chk("addx0_flags", 64'({ex_illegal, ex_rd_we}), 64'b00);
    step(0, 0, 0, 1, 0, 0);

    // Backpressure: 3 stalled cycles, then drain; model checks order and stability.
    j = 0;
    acc0 = dut_accepts;
    for (int c = 0; c < 20 && j < 4; c++) begin
      bit was_ready;
      if (c == 3) chk("bp_accepts_while_stalled", 64'(dut_accepts - acc0), 64'(CAP));
      was_ready = (c >= 3) ? ((CAP == 2) ? (q.size() < 2) : (q.size() == 0 || 1'b1))
                           : ((CAP == 2) ? (q.size() < 2) : (q.size() == 0));
      step(1, bp_inst[j], 64'h2000 + 64'(4 * j), c >= 3, 0, 0);
      if (was_ready) j++;
    end
    chk("bp_all_accepted", 64'(j), 64'd4);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 1, 0, 0);

    // Flush while full
    for (int c = 0; c <= CAP; c++) step(1, rand_inst(), 64'h3000 + 64'(4 * c), 0, 0, 0);
    step(1, 32'h00100093, 64'h3100, 1, 1, 0);
    pc_y = 64'h3200;
    step(1, 32'h00200113, pc_y, 1, 0, 0);
    chk("flush_first_accept_pc", ex_pc, pc_y);
    step(0, 0, 0, 1, 0, 0);

    // Reset during a stall drops held work
    for (int c = 0; c <= CAP; c++) step(1, rand_inst(), 64'h4000 + 64'(4 * c), 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    expect_zero_outputs();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, rand_inst(), {$urandom, $urandom}, ($urandom % 3) != 0,
           ($urandom % 40) == 0, ($urandom % 200) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
